// File: rtl/on_off_input_buffer.sv
// One VC's flit FIFO with an on/off hysteresis flag back to the upstream sender.
// The head flit falls through to data_o; a write into a full buffer is dropped and latched in overflow_o.
module on_off_input_buffer #(
    parameter int FLIT_SIZE     = 32,
    parameter int BUFFER_SIZE   = 8,
    parameter int OFF_THRESHOLD = 6,
    parameter int ON_THRESHOLD  = 3,
    localparam int OCC_SIZE     = $clog2(BUFFER_SIZE + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FLIT_SIZE-1:0] data_i,
    input  logic                 valid_i,
    input  logic                 read_i,
    output logic [FLIT_SIZE-1:0] data_o,
    output logic                 is_empty_o,
    output logic                 on_off_o,
    output logic [OCC_SIZE-1:0]  occupancy_o,
    output logic                 overflow_o
);

    localparam int PTR_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
    localparam logic [PTR_W-1:0]    PTR_LAST = PTR_W'(BUFFER_SIZE - 1);
    localparam logic [OCC_SIZE-1:0] OCC_FULL = OCC_SIZE'(BUFFER_SIZE);
    localparam logic [OCC_SIZE-1:0] OCC_OFF  = OCC_SIZE'(OFF_THRESHOLD);
    localparam logic [OCC_SIZE-1:0] OCC_ON   = OCC_SIZE'(ON_THRESHOLD);

    if (ON_THRESHOLD < 0 || ON_THRESHOLD >= OFF_THRESHOLD || OFF_THRESHOLD > BUFFER_SIZE
        || BUFFER_SIZE < 1) begin : g_bad_params
        $error("on_off_input_buffer: need 0 <= ON_THRESHOLD < OFF_THRESHOLD <= BUFFER_SIZE");
    end

    typedef enum logic {ST_ON = 1'b0, ST_OFF = 1'b1} state_t;

    logic [FLIT_SIZE-1:0] r_mem [BUFFER_SIZE];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [OCC_SIZE-1:0]  r_occ;
    logic                 r_empty;
    logic                 r_overflow;
    logic                 r_on_off;
    state_t               r_state;

    logic                 w_rd_acc;
    logic                 w_wr_acc;
    logic                 w_drop;
    logic [OCC_SIZE-1:0]  w_next_occ;
    logic [PTR_W-1:0]     w_wr_ptr_nxt;
    logic [PTR_W-1:0]     w_rd_ptr_nxt;

    // Depth need not be a power of two, so wrap by explicit compare.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_rd_acc     = read_i && (r_occ != '0);
        w_wr_acc     = valid_i && ((r_occ != OCC_FULL) || w_rd_acc);
        w_drop       = valid_i && !w_wr_acc;
        w_wr_ptr_nxt = ptr_inc(r_wr_ptr);
        w_rd_ptr_nxt = ptr_inc(r_rd_ptr);
        w_next_occ   = r_occ;
        if (w_wr_acc && !w_rd_acc) w_next_occ = r_occ + 1'b1;
        else if (w_rd_acc && !w_wr_acc) w_next_occ = r_occ - 1'b1;
    end

    // Storage is not reset; writes are simply blocked while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc) r_mem[r_wr_ptr] <= data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= w_wr_ptr_nxt;
            if (w_rd_acc) r_rd_ptr <= w_rd_ptr_nxt;
            r_occ   <= w_next_occ;
            r_empty <= (w_next_occ == '0);
            if (w_drop) r_overflow <= 1'b1;
        end
    end

    // Hysteresis on the post-edge occupancy so on_off_o moves with occupancy_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_ON;
            r_on_off <= 1'b1;
        end else begin
            case (r_state)
                ST_ON: begin
                    if (w_next_occ >= OCC_OFF) begin
                        r_state  <= ST_OFF;
                        r_on_off <= 1'b0;
                    end
                end
                ST_OFF: begin
                    if (w_next_occ <= OCC_ON) begin
                        r_state  <= ST_ON;
                        r_on_off <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= ST_ON;
                    r_on_off <= 1'b1;
                end
            endcase
        end
    end

    assign data_o      = r_mem[r_rd_ptr];
    assign is_empty_o  = r_empty;
    assign on_off_o    = r_on_off;
    assign occupancy_o = r_occ;
    assign overflow_o  = r_overflow;

endmodule
